// File: rtl/ir_pkg.sv
// NEC infrared protocol constants and FSM state encoding shared by the IR transmitter and receiver.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents:
//   NEC_*     timing defaults in 50 MHz clock cycles
//   IR_*      counter widths and frame size
//   ir_state_t  frame sequencer states
//   nec_frame   builds the 32-bit on-air word from address and command
//   is_mark     true for states where the envelope is low
package ir_pkg;

  localparam int NEC_CLK_HZ       = 50_000_000;
  localparam int NEC_LEAD_MARK    = 450_000;   // 9 ms
  localparam int NEC_LEAD_SPACE   = 225_000;   // 4.5 ms
  localparam int NEC_BIT_MARK     = 28_000;    // 560 us
  localparam int NEC_SPACE0       = 28_000;    // 560 us
  localparam int NEC_SPACE1       = 84_500;    // 1.69 ms
  localparam int NEC_GAP          = 2_000_000; // 40 ms
  localparam int NEC_CARRIER_HALF = 658;       // ~38 kHz carrier

  localparam int IR_DUR_W       = 21;  // duration counter, holds up to NEC_GAP
  localparam int IR_BIT_W       = 6;   // bit counter, counts 0..32
  localparam int NEC_FRAME_BITS = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEAD_M = 3'd1,
    LEAD_S = 3'd2,
    BIT_M  = 3'd3,
    BIT_S  = 3'd4,
    STOP_M = 3'd5,
    GAP_W  = 3'd6
  } ir_state_t;

  // On-air word: address in the low half, then command, then its complement.
  function automatic logic [NEC_FRAME_BITS-1:0] nec_frame(input logic [15:0] addr,
                                                          input logic [7:0]  cmd);
    return {~cmd, cmd, addr};
  endfunction

  function automatic logic is_mark(input ir_state_t s);
    return (s == LEAD_M) || (s == BIT_M) || (s == STOP_M);
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Square-wave carrier gated by the mark envelope, driving the IR emitter.
// Latency: carrier_mod follows enable combinationally; the first half-period is high.
// Backpressure: none; free-running while enable is high.
//
// Ports:
//   iCLK, iRST   clock and asynchronous active-high reset
//   enable       high during a mark
//   carrier_mod  carrier output, forced low while enable is low
module ir_carrier_gen #(
  parameter int HALF = 658
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic enable,
  output logic carrier_mod
);

  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] half_cnt;
  logic          carrier;

  // While disabled the phase is parked high so every mark starts on a
  // rising carrier edge.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      half_cnt <= '0;
      carrier  <= 1'b1;
    end else if (!enable) begin
      half_cnt <= '0;
      carrier  <= 1'b1;
    end else if (half_cnt == CW'(HALF - 1)) begin
      half_cnt <= '0;
      carrier  <= ~carrier;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

  assign carrier_mod = enable & carrier;

endmodule

// File: rtl/ir_transmit.sv
// NEC infrared frame transmitter: leader, 32 data bits LSB first, stop mark, inter-frame gap.
// Latency: oIRDA falls on the first rising edge after iSTART is sampled high in IDLE.
// Backpressure: iSTART is ignored while oBUSY=1; a held iSTART restarts right after oDONE.
//
// Ports:
//   iCLK, iRST      clock and asynchronous active-high reset
//   iSTART          frame request, level-sampled in IDLE
//   iADDR, iCMD     address and command, latched when the frame starts
//   oIRDA           envelope, low = mark, idle high
//   oIRDA_MOD       carrier-modulated emitter drive, high = on
//   oBUSY           frame in progress (any state but IDLE)
//   oDONE           one-cycle pulse after the inter-frame gap
module ir_transmit
  import ir_pkg::*;
#(
  parameter int CLK_HZ       = NEC_CLK_HZ,
  parameter int LEAD_MARK    = NEC_LEAD_MARK,
  parameter int LEAD_SPACE   = NEC_LEAD_SPACE,
  parameter int BIT_MARK     = NEC_BIT_MARK,
  parameter int SPACE0       = NEC_SPACE0,
  parameter int SPACE1       = NEC_SPACE1,
  parameter int GAP          = NEC_GAP,
  parameter int CARRIER_HALF = NEC_CARRIER_HALF
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  input  logic [15:0] iADDR,
  input  logic [7:0]  iCMD,
  output logic        oIRDA,
  output logic        oIRDA_MOD,
  output logic        oBUSY,
  output logic        oDONE
);

  localparam int DUR_MAX = (1 << IR_DUR_W) - 1;

  // Every duration must be non-zero and must fit the duration counter.
  if (CLK_HZ <= 0 || CARRIER_HALF <= 0 ||
      LEAD_MARK  <= 0 || LEAD_MARK  > DUR_MAX ||
      LEAD_SPACE <= 0 || LEAD_SPACE > DUR_MAX ||
      BIT_MARK   <= 0 || BIT_MARK   > DUR_MAX ||
      SPACE0     <= 0 || SPACE0     > DUR_MAX ||
      SPACE1     <= 0 || SPACE1     > DUR_MAX ||
      GAP        <= 0 || GAP        > DUR_MAX) begin : g_param_check
    $error("ir_transmit: timing parameter out of range");
  end

  ir_state_t                 state;
  ir_state_t                 nxt;
  logic [IR_DUR_W-1:0]       dur_cnt;
  logic [IR_DUR_W-1:0]       dur_last;
  logic                      dur_end;
  logic [IR_BIT_W-1:0]       bit_cnt;
  logic                      bit_last;
  logic [NEC_FRAME_BITS-1:0] frame;
  logic                      cur_bit;

  logic mark_q;
  logic busy_q;
  logic done_q;
  logic mark_nxt;
  logic busy_nxt;
  logic done_nxt;

  assign cur_bit  = frame[bit_cnt[4:0]];
  assign bit_last = (bit_cnt == IR_BIT_W'(NEC_FRAME_BITS - 1));

  // Terminal count of the current state; the counter starts at 0 on entry
  // so a state lasts exactly dur_last+1 cycles.
  always_comb begin
    dur_last = '0;
    unique case (state)
      LEAD_M:  dur_last = IR_DUR_W'(LEAD_MARK - 1);
      LEAD_S:  dur_last = IR_DUR_W'(LEAD_SPACE - 1);
      BIT_M:   dur_last = IR_DUR_W'(BIT_MARK - 1);
      BIT_S:   dur_last = cur_bit ? IR_DUR_W'(SPACE1 - 1) : IR_DUR_W'(SPACE0 - 1);
      STOP_M:  dur_last = IR_DUR_W'(BIT_MARK - 1);
      GAP_W:   dur_last = IR_DUR_W'(GAP - 1);
      default: dur_last = '0;
    endcase
  end

  assign dur_end = (dur_cnt == dur_last);

  // Next state and the next values of the registered outputs.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (iSTART)  nxt = LEAD_M;
      LEAD_M:  if (dur_end) nxt = LEAD_S;
      LEAD_S:  if (dur_end) nxt = BIT_M;
      BIT_M:   if (dur_end) nxt = BIT_S;
      BIT_S:   if (dur_end) nxt = bit_last ? STOP_M : BIT_M;
      STOP_M:  if (dur_end) nxt = GAP_W;
      GAP_W:   if (dur_end) nxt = IDLE;
      default: nxt = IDLE;
    endcase

    mark_nxt = is_mark(nxt);
    busy_nxt = (nxt != IDLE);
    done_nxt = (state == GAP_W) && (nxt == IDLE);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Every transition changes state, so a state change is the reload point.
  // The counter is parked at 0 in IDLE so it never free-runs.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      dur_cnt <= '0;
    end else if (state == IDLE || nxt != state) begin
      dur_cnt <= '0;
    end else begin
      dur_cnt <= dur_cnt + 1'b1;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      bit_cnt <= '0;
      frame   <= '0;
    end else if (state == IDLE && iSTART) begin
      bit_cnt <= '0;
      frame   <= nec_frame(iADDR, iCMD);
    end else if (state == BIT_S && dur_end) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Outputs registered from the next state: same timing as a state decode
  // but glitch-free on the LED driver.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      mark_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      mark_q <= mark_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
    end
  end

  assign oIRDA = ~mark_q;
  assign oBUSY = busy_q;
  assign oDONE = done_q;

  ir_carrier_gen #(
    .HALF (CARRIER_HALF)
  ) u_carrier (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .enable      (mark_q),
    .carrier_mod (oIRDA_MOD)
  );

endmodule
